// File: rtl/cache_pkg.sv
// Shared types and sizes for the cache line fill/flush sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cache_pkg;

    localparam int LINE_BEATS  = 16;
    localparam int LINE_ADDR_W = 15;
    localparam int BEAT_W      = 128;
    localparam int CNT_W       = 5;

    localparam logic [CNT_W-1:0] BEAT_END  = CNT_W'(LINE_BEATS);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(LINE_BEATS - 1);
    localparam logic [CNT_W-1:0] BEAT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        WCMD,
        WDATA,
        WDONE,
        RCMD,
        RDATA,
        RDONE
    } seq_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single-bit level crossing into clk.
// Latency: STAGES cycles.
// Backpressure: none.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/cache_line_sequencer.sv
// Moves one 16-beat line between cache port B and a burst memory port.
// Latency: request to busy SYNC_STAGES+1; write beats 17 cycles at full rate; fill write 1 cycle after each read beat.
// Backpressure: holds command until accepted; stalls port-B reads on write-data backpressure; read data has none.
module cache_line_sequencer
    import cache_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                   mem_clk,
    input  logic                   rst,
    input  logic                   mem_rd,
    input  logic                   mem_wr,
    input  logic [LINE_ADDR_W-1:0] waddr,
    input  logic [LINE_ADDR_W-1:0] raddr,
    output logic                   rd_busy,
    output logic                   wr_busy,
    output logic                   cache_rd,
    output logic                   cache_wr,
    output logic [3:0]             cache_addr,
    input  logic [BEAT_W-1:0]      mem_dout,
    output logic [BEAT_W-1:0]      mem_din,
    output logic                   mc_cmd_valid,
    input  logic                   mc_cmd_ready,
    output logic                   mc_cmd_we,
    output logic [LINE_ADDR_W-1:0] mc_cmd_addr,
    output logic                   mc_wdata_valid,
    input  logic                   mc_wdata_ready,
    output logic [BEAT_W-1:0]      mc_wdata,
    input  logic                   mc_rdata_valid,
    input  logic [BEAT_W-1:0]      mc_rdata
);

    logic rd_s;
    logic wr_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_rd_sync (
        .clk (mem_clk),
        .rst (rst),
        .d   (mem_rd),
        .q   (rd_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_wr_sync (
        .clk (mem_clk),
        .rst (rst),
        .d   (mem_wr),
        .q   (wr_s)
    );

    seq_state_t        state, state_nxt;
    logic [CNT_W-1:0]  beat, beat_nxt;
    logic [CNT_W-1:0]  issued, issued_nxt;
    logic              wdat_vld, wdat_vld_nxt;
    logic              fill_pend, fill_pend_nxt;
    logic              rd_busy_nxt, wr_busy_nxt;
    logic [BEAT_W-1:0] din_nxt;
    logic              wbeat_acc;

    assign wbeat_acc      = wdat_vld & mc_wdata_ready;
    assign mc_wdata_valid = wdat_vld;
    assign mc_wdata       = mem_dout;
    assign cache_wr       = fill_pend;

    always_comb begin
        state_nxt     = state;
        beat_nxt      = beat;
        issued_nxt    = issued;
        wdat_vld_nxt  = wdat_vld;
        fill_pend_nxt = 1'b0;
        rd_busy_nxt   = rd_busy;
        wr_busy_nxt   = wr_busy;
        din_nxt       = mem_din;
        cache_rd      = 1'b0;
        cache_addr    = 4'd0;
        mc_cmd_valid  = 1'b0;
        mc_cmd_we     = 1'b0;
        mc_cmd_addr   = '0;

        case (state)
            IDLE: begin
                // Write-back takes priority so a dirty victim is never overwritten by its fill.
                if (wr_s && !wr_busy) begin
                    state_nxt    = WCMD;
                    wr_busy_nxt  = 1'b1;
                    beat_nxt     = '0;
                    issued_nxt   = '0;
                    wdat_vld_nxt = 1'b0;
                end else if (rd_s && !rd_busy) begin
                    state_nxt   = RCMD;
                    rd_busy_nxt = 1'b1;
                    beat_nxt    = '0;
                end
            end
            WCMD: begin
                mc_cmd_valid = 1'b1;
                mc_cmd_we    = 1'b1;
                mc_cmd_addr  = waddr;
                if (mc_cmd_ready) begin
                    state_nxt = WDATA;
                end
            end
            WDATA: begin
                // Port B holds its output while idle, so the presented beat survives a stall.
                cache_rd     = (issued < BEAT_END) && (!wdat_vld || mc_wdata_ready);
                cache_addr   = issued[3:0];
                wdat_vld_nxt = cache_rd | (wdat_vld & ~mc_wdata_ready);
                if (cache_rd) begin
                    issued_nxt = issued + BEAT_ONE;
                end
                if (wbeat_acc) begin
                    beat_nxt = beat + BEAT_ONE;
                    if (beat == BEAT_LAST) begin
                        state_nxt = WDONE;
                    end
                end
            end
            WDONE: begin
                if (!wr_s) begin
                    wr_busy_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            RCMD: begin
                mc_cmd_valid = 1'b1;
                mc_cmd_we    = 1'b0;
                mc_cmd_addr  = raddr;
                if (mc_cmd_ready) begin
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                if (mc_rdata_valid) begin
                    din_nxt       = mc_rdata;
                    fill_pend_nxt = 1'b1;
                end
                if (fill_pend) begin
                    cache_addr = beat[3:0];
                    beat_nxt   = beat + BEAT_ONE;
                    if (beat == BEAT_LAST) begin
                        state_nxt = RDONE;
                    end
                end
            end
            RDONE: begin
                if (!rd_s) begin
                    rd_busy_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            issued    <= '0;
            wdat_vld  <= 1'b0;
            fill_pend <= 1'b0;
            rd_busy   <= 1'b0;
            wr_busy   <= 1'b0;
            mem_din   <= '0;
        end else begin
            state     <= state_nxt;
            beat      <= beat_nxt;
            issued    <= issued_nxt;
            wdat_vld  <= wdat_vld_nxt;
            fill_pend <= fill_pend_nxt;
            rd_busy   <= rd_busy_nxt;
            wr_busy   <= wr_busy_nxt;
            mem_din   <= din_nxt;
        end
    end

endmodule

// File: tb/tb_cache_line_sequencer.sv
// Bench for cache_line_sequencer: port-B and memory-controller models, scoreboards, vector table and random transactions.
module tb_cache_line_sequencer;
    import cache_pkg::*;

    localparam int SYNC = 2;

    logic          mem_clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_rd = 1'b0;
    logic          mem_wr = 1'b0;
    logic [14:0]   waddr = '0;
    logic [14:0]   raddr = '0;
    logic          rd_busy, wr_busy, cache_rd, cache_wr;
    logic [3:0]    cache_addr;
    logic [127:0]  mem_dout = '0;
    logic [127:0]  mem_din;
    logic          mc_cmd_valid, mc_cmd_we;
    logic          mc_cmd_ready = 1'b1;
    logic [14:0]   mc_cmd_addr;
    logic          mc_wdata_valid;
    logic          mc_wdata_ready = 1'b1;
    logic [127:0]  mc_wdata;
    logic          mc_rdata_valid = 1'b0;
    logic [127:0]  mc_rdata = '0;

    cache_line_sequencer #(.SYNC_STAGES(SYNC)) dut (
        .mem_clk        (mem_clk),
        .rst            (rst),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .waddr          (waddr),
        .raddr          (raddr),
        .rd_busy        (rd_busy),
        .wr_busy        (wr_busy),
        .cache_rd       (cache_rd),
        .cache_wr       (cache_wr),
        .cache_addr     (cache_addr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .mc_cmd_valid   (mc_cmd_valid),
        .mc_cmd_ready   (mc_cmd_ready),
        .mc_cmd_we      (mc_cmd_we),
        .mc_cmd_addr    (mc_cmd_addr),
        .mc_wdata_valid (mc_wdata_valid),
        .mc_wdata_ready (mc_wdata_ready),
        .mc_wdata       (mc_wdata),
        .mc_rdata_valid (mc_rdata_valid),
        .mc_rdata       (mc_rdata)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct { logic we; logic [14:0] addr; } cmd_t;
    typedef struct { logic [3:0] a; logic [127:0] d; } cw_t;
    typedef struct {
        logic do_wr; logic do_rd; logic rd_with_wr;
        logic [14:0] wa; logic [14:0] ra;
        int wrdy; int gap; int stall; logic pattern;
        int exp_ncmd; logic exp_we; logic [14:0] exp_addr;
    } vec_t;

    logic [127:0] cache_mem [16];
    cmd_t         cmd_log[$];
    cw_t          cw_log[$];
    cw_t          cw_exp[$];
    logic [127:0] wb_log[$];
    int cyc = 0;
    int wb_at_rdcmd = 0, wcmd_cyc = 0, wlast_cyc = 0;
    int stall_viol = 0, excl_viol = 0, rlat_viol = 0;
    logic rd_cmd_seen = 1'b0;
    int total = 0, bad = 0;
    string cur_tag = "init";

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %0h want %0h", cur_tag, name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge mem_clk);
        #1;
    endtask

    // Cycle counter and port-B memory: one-cycle read latency, output held while idle.
    initial forever begin
        @(posedge mem_clk);
        cyc = cyc + 1;
        if (cache_rd) mem_dout <= cache_mem[cache_addr];
    end

    // Monitor at the falling edge, where handshakes for the coming rising edge are settled.
    initial begin
        logic prev_v, prev_acc, prev_we, prev_rv;
        logic [14:0] prev_addr;
        prev_v = 1'b0; prev_acc = 1'b0; prev_we = 1'b0; prev_rv = 1'b0; prev_addr = '0;
        forever begin
            @(negedge mem_clk);
            if (!rst) begin
                if (mc_cmd_valid && mc_cmd_ready) begin
                    cmd_log.push_back('{mc_cmd_we, mc_cmd_addr});
                    if (mc_cmd_we) wcmd_cyc = cyc;
                    else begin
                        wb_at_rdcmd = wb_log.size();
                        rd_cmd_seen = 1'b1;
                    end
                end
                if (prev_v && !prev_acc &&
                    (!mc_cmd_valid || mc_cmd_we != prev_we || mc_cmd_addr != prev_addr))
                    stall_viol++;
                if (mc_cmd_valid && (cache_rd || cache_wr)) stall_viol++;
                if (mc_wdata_valid && mc_wdata_ready) begin
                    wb_log.push_back(mc_wdata);
                    wlast_cyc = cyc;
                end
                if (cache_wr) begin
                    cw_log.push_back('{cache_addr, mem_din});
                    if (!prev_rv) rlat_viol++;
                end
                if ((rd_busy && wr_busy) || (cache_rd && cache_wr)) excl_viol++;
            end
            prev_v    = mc_cmd_valid & ~rst;
            prev_acc  = mc_cmd_ready;
            prev_we   = mc_cmd_we;
            prev_addr = mc_cmd_addr;
            prev_rv   = mc_rdata_valid;
        end
    end

    task automatic clear_logs;
        cmd_log.delete(); cw_log.delete(); cw_exp.delete(); wb_log.delete();
        stall_viol = 0; excl_viol = 0; rlat_viol = 0; rd_cmd_seen = 1'b0;
        wb_at_rdcmd = -1; wcmd_cyc = 0; wlast_cyc = 0;
    endtask

    task automatic run_txn(input vec_t v);
        int budget, sent, hold, stall_cnt, lat, t0, mism;
        logic wr_done, rd_done, rd_started, busy_seen, timed_out;
        logic [127:0] d;
        logic [127:0] exp_wb [16];
        cmd_t c0, cl;
        sent = 0; hold = 0; stall_cnt = 0; lat = -1; mism = 0;
        wr_done = 1'b0; rd_done = 1'b0; rd_started = 1'b0; busy_seen = 1'b0; timed_out = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cache_mem[k] = {$urandom, $urandom, $urandom, $urandom};
            exp_wb[k] = cache_mem[k];
        end
        clear_logs();
        waddr = v.wa; raddr = v.ra;
        mc_cmd_ready = (v.stall == 0);
        t0 = cyc;
        if (v.do_wr) mem_wr = 1'b1;
        if (v.do_rd && (v.rd_with_wr || !v.do_wr)) begin mem_rd = 1'b1; rd_started = 1'b1; end
        for (budget = 0; budget < 3000; budget++) begin
            tick();
            if (!busy_seen && (wr_busy || rd_busy)) begin busy_seen = 1'b1; lat = cyc - t0; end
            if (v.stall > 0 && mc_cmd_valid && stall_cnt <= v.stall) begin
                stall_cnt++;
                mc_cmd_ready = (stall_cnt > v.stall);
            end
            mc_wdata_ready = ($urandom_range(99) < v.wrdy);
            if (mem_wr && wr_busy) begin mem_wr = 1'b0; wr_done = 1'b1; end
            if (v.do_rd && !rd_started && wr_done) begin mem_rd = 1'b1; rd_started = 1'b1; end
            mc_rdata_valid = 1'b0;
            if (rd_cmd_seen && sent < 16 && $urandom_range(99) >= v.gap) begin
                d = v.pattern ? {8{8'(sent), 8'hA5}} : {$urandom, $urandom, $urandom, $urandom};
                mc_rdata = d;
                mc_rdata_valid = 1'b1;
                cw_exp.push_back('{4'(sent), d});
                sent++;
            end
            if (mem_rd && cw_log.size() == 16) begin
                hold++;
                if (hold == 4) begin
                    chk("rd_busy_hold", 128'(rd_busy), 128'(1));
                    mem_rd = 1'b0; rd_done = 1'b1;
                end
            end
            if ((!v.do_wr || wr_done) && (!v.do_rd || rd_done) && !wr_busy && !rd_busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        mem_wr = 1'b0; mem_rd = 1'b0; mc_rdata_valid = 1'b0; mc_cmd_ready = 1'b1;
        repeat (4) tick();

        chk("timeout", 128'(timed_out), 128'(0));
        chk("ncmd", 128'(cmd_log.size()), 128'(v.exp_ncmd));
        c0 = (cmd_log.size() > 0) ? cmd_log[0] : '{1'bx, 15'bx};
        chk("cmd0_we", 128'(c0.we), 128'(v.exp_we));
        chk("cmd0_addr", 128'(c0.addr), 128'(v.exp_addr));
        chk("busy_lat", 128'(lat), 128'(SYNC + 1));
        chk("excl", 128'(excl_viol), 128'(0));
        chk("cmd_stall", 128'(stall_viol), 128'(0));
        if (v.do_rd) begin
            cl = (cmd_log.size() > 0) ? cmd_log[cmd_log.size()-1] : '{1'bx, 15'bx};
            chk("rcmd_we", 128'(cl.we), 128'(0));
            chk("rcmd_addr", 128'(cl.addr), 128'(v.ra));
            chk("wb_before_rcmd", 128'(wb_at_rdcmd), 128'(v.do_wr ? 16 : 0));
            chk("fill_cnt", 128'(cw_log.size()), 128'(16));
            for (int k = 0; k < 16; k++)
                if (k >= cw_log.size() || k >= cw_exp.size() ||
                    cw_log[k].a !== cw_exp[k].a || cw_log[k].d !== cw_exp[k].d) mism++;
            chk("fill_data", 128'(mism), 128'(0));
            chk("fill_lat", 128'(rlat_viol), 128'(0));
        end
        if (v.do_wr) begin
            mism = 0;
            chk("wb_cnt", 128'(wb_log.size()), 128'(16));
            for (int k = 0; k < 16; k++)
                if (k >= wb_log.size() || wb_log[k] !== exp_wb[k]) mism++;
            chk("wb_data", 128'(mism), 128'(0));
            if (v.wrdy >= 100) chk("wb_17cyc", 128'(wlast_cyc - wcmd_cyc), 128'(17));
        end
    endtask

    task automatic reset_mid_fill;
        int sent;
        logic [127:0] d;
        sent = 0;
        cur_tag = "rst_mid";
        clear_logs();
        raddr = 15'h0222; mc_cmd_ready = 1'b1; mem_rd = 1'b1;
        for (int b = 0; b < 200; b++) begin
            tick();
            mc_rdata_valid = 1'b0;
            if (rd_cmd_seen && sent < 16) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                mc_rdata = d; mc_rdata_valid = 1'b1; sent++;
            end
            if (cw_log.size() >= 7) break;
        end
        chk("beats_before_rst", 128'(cw_log.size()), 128'(7));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_outs", 128'({rd_busy, wr_busy, cache_rd, cache_wr, cache_addr, mc_cmd_valid,
                              mc_cmd_we, mc_cmd_addr, mc_wdata_valid}), 128'(0));
        chk("rst_din", mem_din, 128'(0));
        chk("rst_state", 128'(dut.state), 128'(IDLE));
        mem_rd = 1'b0; mc_rdata_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
    endtask

    vec_t vecs [6];

    initial begin
        vec_t rv;
        vecs[0] = '{1'b0, 1'b1, 1'b0, 15'h0000, 15'h0123, 100, 0,  0,  1'b1, 1, 1'b0, 15'h0123};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 15'h7F00, 15'h0100, 100, 0,  0,  1'b0, 2, 1'b1, 15'h7F00};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 15'h1234, 15'h0000, 50,  0,  0,  1'b0, 1, 1'b1, 15'h1234};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 15'h0000, 15'h0555, 100, 30, 20, 1'b0, 1, 1'b0, 15'h0555};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 15'h0AAA, 15'h0BBB, 70,  20, 0,  1'b0, 2, 1'b1, 15'h0AAA};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 15'h7FFF, 15'h0000, 100, 0,  20, 1'b0, 1, 1'b1, 15'h7FFF};

        repeat (3) tick();
        cur_tag = "reset";
        chk("reset_outs", 128'({rd_busy, wr_busy, cache_rd, cache_wr, cache_addr, mc_cmd_valid,
                                mc_cmd_we, mc_cmd_addr, mc_wdata_valid}), 128'(0));
        chk("reset_din", mem_din, 128'(0));
        rst = 1'b0;
        repeat (2) tick();

        foreach (vecs[i]) begin
            cur_tag = $sformatf("vec%0d", i);
            run_txn(vecs[i]);
        end

        reset_mid_fill();
        cur_tag = "post_rst_fill";
        run_txn(vecs[0]);

        for (int i = 0; i < 8; i++) begin
            cur_tag = $sformatf("rnd%0d", i);
            rv.do_wr = 1'($urandom_range(1));
            rv.do_rd = 1'($urandom_range(1));
            if (!rv.do_wr && !rv.do_rd) rv.do_rd = 1'b1;
            rv.rd_with_wr = 1'($urandom_range(1));
            rv.wa = 15'($urandom);
            rv.ra = 15'($urandom);
            rv.wrdy = int'($urandom_range(100, 30));
            rv.gap = int'($urandom_range(50));
            rv.stall = int'($urandom_range(5));
            rv.pattern = 1'b0;
            rv.exp_ncmd = int'(rv.do_wr) + int'(rv.do_rd);
            rv.exp_we = rv.do_wr;
            rv.exp_addr = rv.do_wr ? rv.wa : rv.ra;
            run_txn(rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_line_sequencer.md
# cache_line_sequencer

Fill/flush sequencer for the 2-way, 256-byte-line CPU cache. It runs in the memory-controller clock domain. It takes line read/write requests from the cache, moves 16 × 128-bit beats between the cache's port-B memory and a burst memory-controller port, and drives the cache's `rd_busy`/`wr_busy` handshake. It sits between the cache and the LPDDR controller front end.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flop stages on `mem_rd`/`mem_wr` (valid range 2–3).

Ports:
- `mem_clk` in 1: memory-controller clock; the only clock in this block.
- `rst` in 1: asynchronous, active-high reset.
- `mem_rd` in 1: line read request from the cache (CPU domain).
- `mem_wr` in 1: line write-back request from the cache (CPU domain).
- `waddr` in 15: write-back line address [22:8]; stable while `mem_wr` is high.
- `raddr` in 15: fill line address [22:8]; stable while `mem_rd` is high.
- `rd_busy` out 1: fill in progress.
- `wr_busy` out 1: write-back in progress.
- `cache_rd` out 1: cache port-B read enable.
- `cache_wr` out 1: cache port-B write enable.
- `cache_addr` out 4: beat index within the line.
- `mem_dout` in 128: cache port-B read data.
- `mem_din` out 128: cache port-B write data.
- `mc_cmd_valid` out 1: burst command valid.
- `mc_cmd_ready` in 1: burst command accept.
- `mc_cmd_we` out 1: 1 = write burst, 0 = read burst.
- `mc_cmd_addr` out 15: line address; each burst is fixed at 16 beats.
- `mc_wdata_valid` out 1: write beat valid.
- `mc_wdata_ready` in 1: write beat accept.
- `mc_wdata` out 128: write beat data; wired directly to `mem_dout`.
- `mc_rdata_valid` in 1: read beat valid; the controller gives no backpressure on this path.
- `mc_rdata` in 128: read beat data.

## Operation
- `mem_rd` and `mem_wr` each pass through a `SYNC_STAGES`-deep synchronizer; their outputs are `rd_s` and `wr_s`.
- States: IDLE, WCMD, WDATA, WDONE, RCMD, RDATA, RDONE.
- IDLE:
  - If `wr_s` is high and `wr_busy` is 0, go to WCMD.
  - Otherwise, if `rd_s` is high and `rd_busy` is 0, go to RCMD.
  - A write request wins when both are present.
- WCMD:
  - Entry sets `wr_busy` to 1 and clears `beat` to 0.
  - Drive `mc_cmd_valid` with `mc_cmd_we` = 1 and `mc_cmd_addr` = `waddr`.
  - On `mc_cmd_ready`, go to WDATA.
- WDATA:
  - `cache_rd` = (`issued` < 16) & (!`mc_wdata_valid` | `mc_wdata_ready`), with `cache_addr` = `issued`.
  - Port-B data appears one cycle after the read. Port B holds its output while disabled, so `mc_wdata` stays stable under backpressure and no skid buffer is needed.
  - `mc_wdata_valid` sets one cycle after `cache_rd` and clears on acceptance unless a new read was issued in the same cycle.
  - After 16 accepted beats, go to WDONE.
- WDONE: when `wr_s` is 0, clear `wr_busy` and go to IDLE. The pending `mem_rd` is then served.
- RCMD:
  - Entry sets `rd_busy` to 1.
  - Drive `mc_cmd_valid` with `mc_cmd_we` = 0 and `mc_cmd_addr` = `raddr`.
  - On `mc_cmd_ready`, go to RDATA.
- RDATA:
  - Each `mc_rdata_valid` registers `mc_rdata` into `mem_din`.
  - The next cycle pulses `cache_wr` with `cache_addr` = `beat`, then increments `beat`.
  - After the 16th `cache_wr`, go to RDONE.
- RDONE: when `rd_s` is 0, clear `rd_busy` and go to IDLE.
- Beat counters are 5 bits, so 16 is distinct from 0. `cache_addr` is the low 4 bits of the counter.
- Reset mid-burst: go to IDLE immediately and abandon the burst. The cache is responsible for re-requesting.

## Timing
- Reset values:
  - State IDLE; all counters 0; synchronizer flops 0.
  - All 1-bit outputs 0.
  - `cache_addr`, `mc_cmd_addr`: 0.
  - `mem_din`: 0.
- Handshake latencies:
  - `mem_wr` high to `wr_busy` high: `SYNC_STAGES`+1 cycles.
  - `mem_rd` high to `rd_busy` high: the same, measured from IDLE.
- Command handshake: `mc_cmd_valid` stays high until `mc_cmd_ready` is seen; `mc_cmd_we` and `mc_cmd_addr` stay constant while valid.
- Write path: with `mc_wdata_ready` held at 1, the 16 beats take 17 cycles from WDATA entry (1 cycle of BRAM latency plus 16 beats).
- Read path: each `cache_wr` occurs exactly 1 cycle after its `mc_rdata_valid`. Back-to-back `mc_rdata_valid` beats must be sustained.
- `wr_busy` and `rd_busy` are never both 1.
- `cache_rd` and `cache_wr` are never both 1.

## Structure
- Shared package `cache_pkg`:
  - State enum.
  - `LINE_BEATS` = 16.
  - `LINE_ADDR_W` = 15.
  - `BEAT_W` = 128.
- Sub-module `sync_ff` (parameterized depth): used for both request synchronizers.

## Test plan
- Fill only: pulse `mem_rd` with `raddr` = 15'h0123 and return beats k = 0..15 with data {8{k,8'hA5}}.
  - Required: a read command at 15'h0123.
  - Required: 16 `cache_wr` pulses with `cache_addr` 0..15 and matching `mem_din`.
  - Required: `rd_busy` drops only after `mem_rd` falls.
- Write-back then fill: hold `mem_wr`, and switch to `mem_rd` when `wr_busy` is seen, with `waddr` = 15'h7F00 and `raddr` = 15'h0100.
  - Required: the write burst fully completes before a read command at 15'h0100 is issued.
- Write backpressure: toggle `mc_wdata_ready` randomly at 50%.
  - Required: `mc_wdata` matches the cache contents at `cache_addr` 0..15 in order.
  - Required: no beat is duplicated or dropped.
- Command stall: hold `mc_cmd_ready` at 0 for 20 cycles.
  - Required: `mc_cmd_valid`, `mc_cmd_we` and `mc_cmd_addr` stay constant.
  - Required: no `cache_rd` or `cache_wr` activity.
- Reset at beat 7 of a fill.
  - Required: all outputs return to 0 asynchronously and the state is IDLE.
  - Required: a new `mem_rd` then completes a full 16-beat fill.
- Simultaneous `mem_wr` and `mem_rd`.
  - Required: the write is served first; `rd_busy` stays 0 until `wr_busy` clears.
